// File: rtl/mbox_if.sv
// Mailbox link between the client bridge (master) and the peer endpoint (slave).
interface mbox_if;
  logic [31:0] mbox_w_dat;
  logic        mbox_w_valid;
  logic        mbox_w_ready;
  logic        mbox_w_done;
  logic        mbox_w_abort;
  logic [31:0] mbox_r_dat;
  logic        mbox_r_valid;
  logic        mbox_r_ready;
  logic        mbox_r_done;
  logic        mbox_r_abort;

  modport master (
    output mbox_w_dat, mbox_w_valid, mbox_w_done, mbox_w_abort, mbox_r_ready,
    input  mbox_w_ready, mbox_r_dat, mbox_r_valid, mbox_r_done, mbox_r_abort
  );

  modport slave (
    input  mbox_w_dat, mbox_w_valid, mbox_w_done, mbox_w_abort, mbox_r_ready,
    output mbox_w_ready, mbox_r_dat, mbox_r_valid, mbox_r_done, mbox_r_abort
  );
endinterface

// File: rtl/mbox_peer.sv
// Peer endpoint of the mailbox link: RX packet FIFO, TX output register
// and the two-way abort handshake.
module mbox_peer #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          aclk,
  input  logic          resetn,
  mbox_if.slave         mbox,
  output logic [31:0]   rx_data,
  output logic          rx_last,
  output logic          rx_valid,
  input  logic          rx_ready,
  output logic [AW:0]   rx_pkts,
  input  logic [31:0]   tx_data,
  input  logic          tx_last,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic          abort_req,
  output logic          abort_busy,
  output logic          err
);
  localparam int unsigned PW = AW + 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
  localparam logic [1:0] ST_FLUSH_ACK = 2'd2;
  localparam logic [1:0] ST_FLUSH     = 2'd3;

  logic [1:0]    r_state, w_state_nxt;
  logic [32:0]   r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr, r_rx_pkts;
  logic          r_have_word, r_err, r_tx_last;
  logic [31:0]   r_r_dat;
  logic          r_r_valid, r_r_done, r_r_abort;

  logic          w_idle, w_full, w_empty, w_flush;
  logic          w_wr, w_pop, w_pop_last, w_done_ok, w_done_bad;
  logic          w_abort_start, w_tx_load, w_tx_xfer, w_r_abort_nxt;
  logic [AW-1:0] w_wr_idx, w_rd_idx, w_prev_idx;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_flush    = (r_state == ST_FLUSH) || (r_state == ST_FLUSH_ACK);
  assign w_wr_idx   = r_wr_ptr[AW-1:0];
  assign w_rd_idx   = r_rd_ptr[AW-1:0];
  assign w_prev_idx = w_wr_idx - AW'(1);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (w_wr_idx == w_rd_idx);
  assign w_empty    = (r_wr_ptr == r_rd_ptr);

  assign w_wr       = mbox.mbox_w_valid && mbox.mbox_w_ready;
  assign w_pop      = rx_valid && rx_ready;
  assign w_pop_last = w_pop && r_mem[w_rd_idx][32];
  // A done is only meaningful if some word arrived since the previous one.
  assign w_done_ok  = w_idle && mbox.mbox_w_done && (r_have_word || w_wr);
  assign w_done_bad = w_idle && mbox.mbox_w_done && !r_have_word && !w_wr;

  assign w_abort_start = w_idle && (mbox.mbox_w_abort || abort_req);
  assign w_tx_load     = tx_valid && tx_ready;
  assign w_tx_xfer     = r_r_valid && mbox.mbox_r_ready;

  assign mbox.mbox_w_ready = !w_full && w_idle;
  assign mbox.mbox_r_dat   = r_r_dat;
  assign mbox.mbox_r_valid = r_r_valid;
  assign mbox.mbox_r_done  = r_r_done;
  assign mbox.mbox_r_abort = r_r_abort;

  assign rx_valid   = !w_empty && w_idle;
  assign rx_data    = rx_valid ? r_mem[w_rd_idx][31:0] : 32'd0;
  assign rx_last    = rx_valid && r_mem[w_rd_idx][32];
  assign rx_pkts    = r_rx_pkts;
  assign tx_ready   = (!r_r_valid || mbox.mbox_r_ready) && w_idle;
  assign abort_busy = !w_idle;
  assign err        = r_err;

  // Abort handshake next-state and abort pulse request.
  always_comb begin
    w_state_nxt   = r_state;
    w_r_abort_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (mbox.mbox_w_abort) begin
          w_state_nxt = abort_req ? ST_FLUSH : ST_FLUSH_ACK;
        end else if (abort_req) begin
          w_state_nxt   = ST_WAIT_ACK;
          w_r_abort_nxt = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (mbox.mbox_w_abort) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH_ACK: begin
        w_state_nxt   = ST_IDLE;
        w_r_abort_nxt = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_r_abort <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_r_abort <= w_r_abort_nxt;
    end
  end

  // FIFO storage; a bare done back-patches the last bit of the newest entry.
  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[w_wr_idx] <= {w_done_ok, mbox.mbox_w_dat};
    end else if (w_done_ok) begin
      r_mem[w_prev_idx][32] <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rx_pkts   <= '0;
      r_have_word <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_flush) begin
      r_rd_ptr    <= r_wr_ptr;
      r_rx_pkts   <= '0;
      r_have_word <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_done_ok && !w_pop_last)      r_rx_pkts <= r_rx_pkts + PW'(1);
      else if (!w_done_ok && w_pop_last) r_rx_pkts <= r_rx_pkts - PW'(1);
      if (w_done_ok)  r_have_word <= 1'b0;
      else if (w_wr)  r_have_word <= 1'b1;
      if (w_done_bad) r_err <= 1'b1;
    end
  end

  // TX output register; a word finishing as an abort starts gets no done.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      r_r_dat   <= '0;
      r_r_valid <= 1'b0;
      r_tx_last <= 1'b0;
      r_r_done  <= 1'b0;
    end else begin
      r_r_done <= w_tx_xfer && r_tx_last && w_idle && !w_abort_start;
      if (w_flush) begin
        r_r_valid <= 1'b0;
        r_tx_last <= 1'b0;
      end else if (w_tx_load) begin
        r_r_dat   <= tx_data;
        r_r_valid <= 1'b1;
        r_tx_last <= tx_last;
      end else if (w_tx_xfer) begin
        r_r_valid <= 1'b0;
        r_tx_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mbox_peer.sv
// Directed bench for mbox_peer: RX packet table plus hand-written
// sequences for backpressure, err, TX stall and both abort flavours.
module tb_mbox_peer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          aclk = 1'b0;
  logic          resetn;
  logic [31:0]   rx_data, tx_data;
  logic          rx_last, rx_valid, rx_ready;
  logic [AW:0]   rx_pkts;
  logic          tx_last, tx_valid, tx_ready;
  logic          abort_req, abort_busy, err;

  int total = 0;
  int bad   = 0;
  int pulses;

  always #5 aclk = ~aclk;

  mbox_if mb ();

  mbox_peer #(.DEPTH(DEPTH)) dut (
    .aclk       (aclk),
    .resetn     (resetn),
    .mbox       (mb),
    .rx_data    (rx_data),
    .rx_last    (rx_last),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_pkts    (rx_pkts),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .abort_req  (abort_req),
    .abort_busy (abort_busy),
    .err        (err)
  );

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic        wdone;
    logic        rr;
    logic        e_rv;
    logic [31:0] e_rd;
    logic        e_rl;
    logic        e_wr;
    logic [3:0]  e_pk;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b1;
    mb.mbox_w_dat = '0; mb.mbox_w_valid = 1'b0; mb.mbox_w_done = 1'b0;
    mb.mbox_w_abort = 1'b0; mb.mbox_r_ready = 1'b0;
    rx_ready = 1'b0; tx_data = '0; tx_last = 1'b0; tx_valid = 1'b0; abort_req = 1'b0;
    #3 resetn = 1'b0;
    #2;
    chk("rst w_ready",  32'(mb.mbox_w_ready), 32'd1);
    chk("rst rx_valid", 32'(rx_valid), 32'd0);
    chk("rst rx_data",  rx_data, 32'd0);
    chk("rst rx_pkts",  32'(rx_pkts), 32'd0);
    chk("rst r_valid",  32'(mb.mbox_r_valid), 32'd0);
    chk("rst r_dat",    mb.mbox_r_dat, 32'd0);
    chk("rst r_done",   32'(mb.mbox_r_done), 32'd0);
    chk("rst r_abort",  32'(mb.mbox_r_abort), 32'd0);
    chk("rst busy",     32'(abort_busy), 32'd0);
    chk("rst err",      32'(err), 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    // 3-word packet, done alone, then drain
    vt[0] = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 4'd0};
    vt[1] = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 4'd0};
    vt[2] = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 4'd0};
    vt[3] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 4'd0};
    vt[4] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 4'd1};
    vt[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 4'd1};
    vt[6] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 1'b1, 4'd1};
    vt[7] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 4'd0};
    for (int i = 0; i < 8; i++) begin
      mb.mbox_w_valid = vt[i].wv;
      mb.mbox_w_dat   = vt[i].wd;
      mb.mbox_w_done  = vt[i].wdone;
      rx_ready        = vt[i].rr;
      #1;
      chk($sformatf("pkt[%0d] rx_valid", i), 32'(rx_valid), 32'(vt[i].e_rv));
      chk($sformatf("pkt[%0d] rx_data", i),  rx_data, vt[i].e_rd);
      chk($sformatf("pkt[%0d] rx_last", i),  32'(rx_last), 32'(vt[i].e_rl));
      chk($sformatf("pkt[%0d] w_ready", i),  32'(mb.mbox_w_ready), 32'(vt[i].e_wr));
      chk($sformatf("pkt[%0d] rx_pkts", i),  32'(rx_pkts), 32'(vt[i].e_pk));
      tick();
    end
    mb.mbox_w_valid = 1'b0; mb.mbox_w_done = 1'b0; rx_ready = 1'b0;

    // Fill to full, pop one, write 9th, drain in order
    mb.mbox_w_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mb.mbox_w_dat = 32'h100 + 32'(i);
      #1 chk($sformatf("fill[%0d] w_ready", i), 32'(mb.mbox_w_ready), 32'd1);
      tick();
    end
    mb.mbox_w_dat = 32'hDEAD;
    #1 chk("full w_ready", 32'(mb.mbox_w_ready), 32'd0);
    tick();
    mb.mbox_w_valid = 1'b0; rx_ready = 1'b1;
    #1 chk("full pop data", rx_data, 32'h100);
    chk("full pop w_ready same cycle", 32'(mb.mbox_w_ready), 32'd0);
    tick();
    rx_ready = 1'b0;
    #1 chk("after pop w_ready", 32'(mb.mbox_w_ready), 32'd1);
    mb.mbox_w_valid = 1'b1; mb.mbox_w_dat = 32'h108; mb.mbox_w_done = 1'b1;
    tick();
    mb.mbox_w_valid = 1'b0; mb.mbox_w_done = 1'b0;
    #1 chk("refull w_ready", 32'(mb.mbox_w_ready), 32'd0);
    chk("refull rx_pkts", 32'(rx_pkts), 32'd1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1 chk($sformatf("drain[%0d] data", i), rx_data, 32'h100 + 32'(i));
      chk($sformatf("drain[%0d] last", i), 32'(rx_last), (i == 8) ? 32'd1 : 32'd0);
      tick();
    end
    rx_ready = 1'b0;
    #1 chk("drained rx_valid", 32'(rx_valid), 32'd0);
    chk("drained rx_pkts", 32'(rx_pkts), 32'd0);

    // Double done -> err, then buffer 5 words for the client abort
    mb.mbox_w_valid = 1'b1; mb.mbox_w_dat = 32'h55;
    tick();
    mb.mbox_w_valid = 1'b0; mb.mbox_w_done = 1'b1;
    tick();
    #1 chk("done1 err", 32'(err), 32'd0);
    chk("done1 rx_pkts", 32'(rx_pkts), 32'd1);
    tick();
    mb.mbox_w_done = 1'b0;
    #1 chk("done2 err", 32'(err), 32'd1);
    chk("done2 rx_pkts", 32'(rx_pkts), 32'd1);
    mb.mbox_w_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mb.mbox_w_dat = 32'h60 + 32'(i);
      tick();
    end
    mb.mbox_w_valid = 1'b0;
    #1 chk("err sticky", 32'(err), 32'd1);
    chk("5 buffered rx_data", rx_data, 32'h55);
    chk("5 buffered rx_last", 32'(rx_last), 32'd1);

    // Client-initiated abort
    mb.mbox_w_abort = 1'b1;
    tick();
    mb.mbox_w_abort = 1'b0;
    #1 chk("cab busy", 32'(abort_busy), 32'd1);
    chk("cab w_ready", 32'(mb.mbox_w_ready), 32'd0);
    chk("cab rx_valid", 32'(rx_valid), 32'd0);
    chk("cab r_abort early", 32'(mb.mbox_r_abort), 32'd0);
    tick();
    #1 chk("cab r_abort", 32'(mb.mbox_r_abort), 32'd1);
    chk("cab busy end", 32'(abort_busy), 32'd0);
    chk("cab rx_pkts", 32'(rx_pkts), 32'd0);
    chk("cab rx_valid end", 32'(rx_valid), 32'd0);
    chk("cab err cleared", 32'(err), 32'd0);
    chk("cab w_ready end", 32'(mb.mbox_w_ready), 32'd1);
    tick();
    #1 chk("cab r_abort one cycle", 32'(mb.mbox_r_abort), 32'd0);

    // TX 2-word packet with stall on the last word
    tx_valid = 1'b1; tx_data = 32'hA; tx_last = 1'b0; mb.mbox_r_ready = 1'b0;
    #1 chk("tx A ready", 32'(tx_ready), 32'd1);
    tick();
    tx_data = 32'hB; tx_last = 1'b1; mb.mbox_r_ready = 1'b1;
    #1 chk("tx A valid", 32'(mb.mbox_r_valid), 32'd1);
    chk("tx A dat", mb.mbox_r_dat, 32'hA);
    chk("tx B ready", 32'(tx_ready), 32'd1);
    tick();
    tx_valid = 1'b0; mb.mbox_r_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("tx stall[%0d] dat", k), mb.mbox_r_dat, 32'hB);
      chk($sformatf("tx stall[%0d] valid", k), 32'(mb.mbox_r_valid), 32'd1);
      chk($sformatf("tx stall[%0d] done", k), 32'(mb.mbox_r_done), 32'd0);
      chk($sformatf("tx stall[%0d] tx_ready", k), 32'(tx_ready), 32'd0);
      tick();
    end
    mb.mbox_r_ready = 1'b1;
    #1 chk("tx B hs done", 32'(mb.mbox_r_done), 32'd0);
    tick();
    mb.mbox_r_ready = 1'b0;
    #1 chk("tx after valid", 32'(mb.mbox_r_valid), 32'd0);
    chk("tx done pulse", 32'(mb.mbox_r_done), 32'd1);
    tick();
    #1 chk("tx done once", 32'(mb.mbox_r_done), 32'd0);

    // Local abort while a last word completes; stall for the ack
    tx_valid = 1'b1; tx_data = 32'hC; tx_last = 1'b1;
    tick();
    tx_valid = 1'b0; mb.mbox_r_ready = 1'b1; abort_req = 1'b1;
    #1 chk("lab r_valid pre", 32'(mb.mbox_r_valid), 32'd1);
    tick();
    abort_req = 1'b0; mb.mbox_r_ready = 1'b0;
    #1 chk("lab r_abort", 32'(mb.mbox_r_abort), 32'd1);
    chk("lab busy", 32'(abort_busy), 32'd1);
    chk("lab word taken", 32'(mb.mbox_r_valid), 32'd0);
    chk("lab no done", 32'(mb.mbox_r_done), 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) abort_req = 1'b1;
      tick();
      abort_req = 1'b0;
      #1 if (mb.mbox_r_abort) pulses++;
      chk($sformatf("wait[%0d] busy", k), 32'(abort_busy), 32'd1);
      chk($sformatf("wait[%0d] done", k), 32'(mb.mbox_r_done), 32'd0);
    end
    chk("wait extra pulses", 32'(pulses), 32'd0);
    mb.mbox_w_abort = 1'b1;
    tick();
    mb.mbox_w_abort = 1'b0;
    #1 chk("ack flush busy", 32'(abort_busy), 32'd1);
    tick();
    #1 chk("ack idle busy", 32'(abort_busy), 32'd0);
    chk("ack r_abort", 32'(mb.mbox_r_abort), 32'd0);
    chk("ack w_ready", 32'(mb.mbox_w_ready), 32'd1);

    // Simultaneous local request and client abort: no pulse at all
    abort_req = 1'b1; mb.mbox_w_abort = 1'b1;
    tick();
    abort_req = 1'b0; mb.mbox_w_abort = 1'b0;
    pulses = 0;
    #1 chk("sim busy", 32'(abort_busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (mb.mbox_r_abort) pulses++;
      tick();
      #1;
    end
    chk("sim pulses", 32'(pulses), 32'd0);
    chk("sim idle", 32'(abort_busy), 32'd0);

    // Asynchronous reset mid-operation
    mb.mbox_w_valid = 1'b1; mb.mbox_w_dat = 32'h77;
    tx_valid = 1'b1; tx_data = 32'h99; tx_last = 1'b1;
    tick();
    mb.mbox_w_valid = 1'b0; tx_valid = 1'b0;
    #1 chk("pre-rst rx_valid", 32'(rx_valid), 32'd1);
    chk("pre-rst r_valid", 32'(mb.mbox_r_valid), 32'd1);
    resetn = 1'b0;
    #1 chk("mid-rst rx_valid", 32'(rx_valid), 32'd0);
    chk("mid-rst r_valid", 32'(mb.mbox_r_valid), 32'd0);
    chk("mid-rst r_dat", mb.mbox_r_dat, 32'd0);
    chk("mid-rst w_ready", 32'(mb.mbox_w_ready), 32'd1);
    chk("mid-rst r_abort", 32'(mb.mbox_r_abort), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    #1 chk("post-rst r_done", 32'(mb.mbox_r_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
